bit_scan_engine: RTL and testbench

Parametrised, multi-cycle bit-position scanner. Accepts a WIDTH-bit word with a valid/ready handshake and scans it CHUNK bits per clock, starting at the LSB, for the lowest bit equal to a requested match value (0 or 1). It returns the bit position, or WIDTH when no bit matches. It sits between status/flag registers and allocator logic, where free-slot and pending-bit searches are needed without a full-width single-cycle priority encoder.

---
 rtl/bit_scan_engine.sv | 116 +++++++++++
 tb/tb_bit_scan_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bit_scan_engine.sv
// Multi-cycle lowest-bit scanner: finds the first bit equal to in_match, CHUNK bits per clock.
// Optional macro BIT_SCAN_ITER_EN enables iterate mode (enumerate every match, then a terminator).
module bit_scan_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned POSW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POSW-1:0]  out_pos,
  output logic             out_found,
  output logic             out_last
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned OFFW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic             match_r;
  logic [KW-1:0]    k;

  logic [POSW-1:0]  base;
  logic [CHUNK-1:0] bits;
  logic [CHUNK-1:0] hits;
  logic             hit;
  logic [OFFW-1:0]  off;
  logic             last_chunk;

  assign in_ready = (state == IDLE);

  // Priority encode the current chunk; descending loop leaves the lowest match in off.
  always_comb begin
    base       = POSW'(k) * POSW'(CHUNK);
    bits       = CHUNK'(word >> base);
    hits       = match_r ? bits : ~bits;
    hit        = |hits;
    last_chunk = (k == KW'(NCHUNK - 1));
    off        = '0;
    for (int unsigned i = CHUNK; i > 0; i--) begin
      if (hits[i-1]) off = OFFW'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      match_r   <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_found <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word    <= in_data;
            match_r <= in_match;
            k       <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            out_pos   <= base + POSW'(off);
            out_found <= 1'b1;
            out_valid <= 1'b1;
`ifdef BIT_SCAN_ITER_EN
            out_last  <= 1'b0;
`else
            out_last  <= 1'b1;
`endif
            state     <= DONE;
          end else if (last_chunk) begin
            out_pos   <= POSW'(WIDTH);
            out_found <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef BIT_SCAN_ITER_EN
            // Knock out the reported bit and rescan from the same chunk.
            if (out_found) begin
              word[out_pos[POSW-2:0]] <= ~match_r;
              state                   <= SCAN;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_engine.sv
// Scoreboard bench for bit_scan_engine (WIDTH=32, CHUNK=8); driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_bit_scan_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_match;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_pos;
  logic        out_found;
  logic        out_last;

  typedef struct packed {
    logic [5:0] pos;
    logic       found;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit_scan_engine #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_match(in_match),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_found(out_found), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_pos), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pos",   32'(out_pos),   32'(e.pos));
        chk("out_found", 32'(out_found), 32'(e.found));
        chk("out_last",  32'(out_last),  32'(e.last));
      end
    end
  end

  task automatic push_expected(input logic [31:0] data, input logic match, input int first_pos);
`ifdef BIT_SCAN_ITER_EN
    if (first_pos < 32) begin
      exp_q.push_back('{pos: 6'(first_pos), found: 1'b1, last: 1'b0});
      for (int b = first_pos + 1; b < 32; b++)
        if (data[b] == match) exp_q.push_back('{pos: 6'(b), found: 1'b1, last: 1'b0});
    end
    exp_q.push_back('{pos: 6'd32, found: 1'b0, last: 1'b1});
`else
    exp_q.push_back('{pos: 6'(first_pos), found: first_pos < 32, last: 1'b1});
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(in_ready), 32'd1);
  endtask

  // Issue one request; check first-result latency in edges after the accept edge.
  task automatic send(input logic [31:0] data, input logic match, input int first_pos,
                      input int exp_lat, input bit drain);
    int lat = 0;
    push_expected(data, match, first_pos);
    in_data  = data;
    in_match = match;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (drain) wait_idle("drain");
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_match  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pos",   32'(out_pos),   32'd0);
    chk("rst_out_found", 32'(out_found), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h0000_0088, 1'b1,  3, 1, 1'b1);
    send(32'h0000_0088, 1'b0,  0, 1, 1'b1);
    send(32'h0001_0000, 1'b1, 16, 3, 1'b1);
    send(32'h0000_0000, 1'b1, 32, 4, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 32, 4, 1'b1);
    send(32'h8000_0009, 1'b1,  0, 1, 1'b1);
    send(32'h8000_0000, 1'b1, 31, 4, 1'b1);
    send(32'hFFFF_FEFF, 1'b0,  8, 2, 1'b1);

    // Backpressure: result held for 5 cycles with out_ready low.
    out_ready = 1'b0;
    send(32'h0000_0100, 1'b1, 8, 2, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pos",   32'(out_pos),   32'd8);
      chk("bp_found", 32'(out_found), 32'd1);
      chk("bp_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
`ifndef BIT_SCAN_ITER_EN
    chk("bp_in_ready_after", 32'(in_ready),  32'd1);
    chk("bp_valid_after",    32'(out_valid), 32'd0);
`endif
    wait_idle("bp_drain");

    // Reset mid-scan.
    in_data  = 32'h8000_0000;
    in_match = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0004, 1'b1, 2, 1, 1'b1);

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
